// File: rtl/tdm_demux_2bit_1x4.sv
// tdm_demux_2bit_1x4: receive end of a 2-bit 4-slot TDM link, publishing frames atomically to A-D
module tdm_demux_2bit_1x4 #(
  parameter bit SYNC_EVERY_FRAME = 1'b0
) (
  input  logic Clk,
  input  logic Rst,
  input  logic In1,
  input  logic In0,
  input  logic Valid,
  input  logic Sync,
  output logic A1,
  output logic A0,
  output logic B1,
  output logic B0,
  output logic C1,
  output logic C0,
  output logic D1,
  output logic D0,
  output logic S1,
  output logic S0,
  output logic FrameDone,
  output logic SyncErr
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [1:0] smp, cnt, cnt_nx, sh_a, sh_b, sh_c, a, b, c, d;
  logic run, vs, vn, drop0, wr_a, wr_b, wr_c, pub, err;
  assign smp = {In1, In0};
  always_ff @(posedge Clk)
    if (Rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (Valid && state == IDLE) state_nx = Sync ? RUN : IDLE;
    else if (drop0) state_nx = IDLE;
  end
  always_comb begin
    run    = state == RUN;
    vs     = Valid & Sync;
    vn     = Valid & ~Sync & run;
    drop0  = vn && cnt == 2'd0 && SYNC_EVERY_FRAME;
    wr_a   = vs | (vn && cnt == 2'd0 && !SYNC_EVERY_FRAME);
    wr_b   = vn && cnt == 2'd1;
    wr_c   = vn && cnt == 2'd2;
    pub    = vn && cnt == 2'd3;
    err    = (vs && run && cnt != 2'd0) | drop0;
    cnt_nx = wr_a ? 2'd1 : (wr_b | wr_c) ? cnt + 2'd1 : pub ? 2'd0 : cnt;
  end
  // a resync simply restarts the shadow fill; stale B/C shadows are overwritten before any publish
  always_ff @(posedge Clk)
    if (Rst) begin
      cnt       <= 2'd0;
      sh_a      <= 2'd0;
      sh_b      <= 2'd0;
      sh_c      <= 2'd0;
      a         <= 2'd0;
      b         <= 2'd0;
      c         <= 2'd0;
      d         <= 2'd0;
      FrameDone <= 1'b0;
      SyncErr   <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      FrameDone <= pub;
      SyncErr   <= err;
      if (wr_a) sh_a <= smp;
      if (wr_b) sh_b <= smp;
      if (wr_c) sh_c <= smp;
      if (pub) begin
        a <= sh_a;
        b <= sh_b;
        c <= sh_c;
        d <= smp;
      end
    end
  assign {A1, A0} = a;
  assign {B1, B0} = b;
  assign {C1, C0} = c;
  assign {D1, D0} = d;
  assign {S1, S0} = cnt;
endmodule

// File: tb/tb_tdm_demux_2bit_1x4.sv
// tb_tdm_demux_2bit_1x4: directed checks on two instances, one per SYNC_EVERY_FRAME setting
module tb_tdm_demux_2bit_1x4;
  logic clk = 1'b0, rst, in1, in0, valid, sync;
  logic a1_0, a0_0, b1_0, b0_0, c1_0, c0_0, d1_0, d0_0, s1_0, s0_0, fd_0, se_0;
  logic a1_1, a0_1, b1_1, b0_1, c1_1, c0_1, d1_1, d0_1, s1_1, s0_1, fd_1, se_1;
  logic [7:0] w0, w1;
  logic [1:0] sl0, sl1;
  int tests = 0, failed = 0;
  always #5 clk = ~clk;
  tdm_demux_2bit_1x4 #(.SYNC_EVERY_FRAME(1'b0)) dut0 (
    .Clk(clk), .Rst(rst), .In1(in1), .In0(in0), .Valid(valid), .Sync(sync),
    .A1(a1_0), .A0(a0_0), .B1(b1_0), .B0(b0_0), .C1(c1_0), .C0(c0_0), .D1(d1_0), .D0(d0_0),
    .S1(s1_0), .S0(s0_0), .FrameDone(fd_0), .SyncErr(se_0));
  tdm_demux_2bit_1x4 #(.SYNC_EVERY_FRAME(1'b1)) dut1 (
    .Clk(clk), .Rst(rst), .In1(in1), .In0(in0), .Valid(valid), .Sync(sync),
    .A1(a1_1), .A0(a0_1), .B1(b1_1), .B0(b0_1), .C1(c1_1), .C0(c0_1), .D1(d1_1), .D0(d0_1),
    .S1(s1_1), .S0(s0_1), .FrameDone(fd_1), .SyncErr(se_1));
  assign w0  = {a1_0, a0_0, b1_0, b0_0, c1_0, c0_0, d1_0, d0_0};
  assign w1  = {a1_1, a0_1, b1_1, b0_1, c1_1, c0_1, d1_1, d0_1};
  assign sl0 = {s1_0, s0_0};
  assign sl1 = {s1_1, s0_1};

  task automatic step(input logic v, input logic s, input logic [1:0] dat);
    valid = v;
    sync = s;
    {in1, in0} = dat;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step(1'b1, 1'b1, 2'b11);
    rst = 1'b0;
  endtask

  task automatic good_frame();
    step(1'b1, 1'b1, 2'b00);
    step(1'b1, 1'b0, 2'b01);
    step(1'b1, 1'b0, 2'b10);
    step(1'b1, 1'b0, 2'b11);
  endtask

  task automatic test_reset();
    do_reset(2);
    tests++;
    if ({w0, sl0, fd_0, se_0} !== 12'h0) begin
      failed++;
      $display("FAIL reset_dut0 got %h expected 000", {w0, sl0, fd_0, se_0});
    end
    tests++;
    if ({w1, sl1, fd_1, se_1} !== 12'h0) begin
      failed++;
      $display("FAIL reset_dut1 got %h expected 000", {w1, sl1, fd_1, se_1});
    end
  endtask

  task automatic test_aligned_frame();
    logic [1:0] exp_s [4];
    logic [1:0] dat [4];
    exp_s = '{2'b01, 2'b10, 2'b11, 2'b00};
    dat = '{2'b00, 2'b01, 2'b10, 2'b11};
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i == 0, dat[i]);
      tests++;
      if (sl0 !== exp_s[i]) begin
        failed++;
        $display("FAIL aligned_slot%0d got %b expected %b", i, sl0, exp_s[i]);
      end
      tests++;
      if (fd_0 !== (i == 3)) begin
        failed++;
        $display("FAIL aligned_fd%0d got %b expected %b", i, fd_0, i == 3);
      end
      tests++;
      if (w0 !== (i == 3 ? 8'h1B : 8'h00)) begin
        failed++;
        $display("FAIL aligned_words%0d got %h expected %h", i, w0, i == 3 ? 8'h1B : 8'h00);
      end
    end
    step(1'b0, 1'b0, 2'b00);
    tests++;
    if (fd_0 !== 1'b0 || w0 !== 8'h1B) begin
      failed++;
      $display("FAIL aligned_after got fd=%b w=%h expected fd=0 w=1b", fd_0, w0);
    end
  endtask

  task automatic test_gapped_back_to_back();
    int fd_cnt = 0;
    do_reset(1);
    step(1'b1, 1'b1, 2'b00);
    step(1'b1, 1'b0, 2'b01);
    repeat (3) step(1'b0, 1'b1, 2'b11);
    tests++;
    if (w0 !== 8'h00 || sl0 !== 2'b10) begin
      failed++;
      $display("FAIL gap_hold got w=%h s=%b expected w=00 s=10", w0, sl0);
    end
    step(1'b1, 1'b0, 2'b10);
    step(1'b1, 1'b0, 2'b11);
    tests++;
    if (w0 !== 8'h1B || fd_0 !== 1'b1) begin
      failed++;
      $display("FAIL gap_publish got w=%h fd=%b expected w=1b fd=1", w0, fd_0);
    end
    step(1'b1, 1'b0, 2'b11);
    fd_cnt += int'(fd_0);
    step(1'b1, 1'b0, 2'b10);
    fd_cnt += int'(fd_0);
    step(1'b1, 1'b0, 2'b01);
    fd_cnt += int'(fd_0);
    tests++;
    if (w0 !== 8'h1B) begin
      failed++;
      $display("FAIL b2b_hold got %h expected 1b", w0);
    end
    step(1'b1, 1'b0, 2'b00);
    fd_cnt += int'(fd_0);
    tests++;
    if (w0 !== 8'hE4 || fd_cnt != 1) begin
      failed++;
      $display("FAIL b2b_publish got w=%h fd_count=%0d expected w=e4 fd_count=1", w0, fd_cnt);
    end
  endtask

  task automatic test_unaligned();
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 2'b11);
      tests++;
      if ({sl0, fd_0, se_0, w0} !== 12'h0) begin
        failed++;
        $display("FAIL unaligned%0d got %h expected 000", i, {sl0, fd_0, se_0, w0});
      end
    end
  endtask

  task automatic test_early_resync();
    do_reset(1);
    good_frame();
    step(1'b1, 1'b1, 2'b10);
    step(1'b1, 1'b0, 2'b10);
    step(1'b1, 1'b1, 2'b01);
    tests++;
    if (se_0 !== 1'b1 || sl0 !== 2'b01 || w0 !== 8'h1B) begin
      failed++;
      $display("FAIL resync_err got se=%b s=%b w=%h expected se=1 s=01 w=1b", se_0, sl0, w0);
    end
    step(1'b1, 1'b0, 2'b00);
    tests++;
    if (se_0 !== 1'b0 || sl0 !== 2'b10) begin
      failed++;
      $display("FAIL resync_pulse got se=%b s=%b expected se=0 s=10", se_0, sl0);
    end
    step(1'b1, 1'b0, 2'b11);
    step(1'b1, 1'b0, 2'b10);
    tests++;
    if (w0 !== 8'h4E || fd_0 !== 1'b1) begin
      failed++;
      $display("FAIL resync_publish got w=%h fd=%b expected w=4e fd=1", w0, fd_0);
    end
  endtask

  task automatic test_missing_sync();
    do_reset(1);
    good_frame();
    step(1'b1, 1'b0, 2'b11);
    tests++;
    if (se_1 !== 1'b1 || sl1 !== 2'b00 || w1 !== 8'h1B) begin
      failed++;
      $display("FAIL missing_sync got se=%b s=%b w=%h expected se=1 s=00 w=1b", se_1, sl1, w1);
    end
    tests++;
    if (se_0 !== 1'b0 || sl0 !== 2'b01) begin
      failed++;
      $display("FAIL missing_sync_lenient got se=%b s=%b expected se=0 s=01", se_0, sl0);
    end
    step(1'b1, 1'b0, 2'b01);
    tests++;
    if (se_1 !== 1'b0 || sl1 !== 2'b00) begin
      failed++;
      $display("FAIL missing_sync_idle got se=%b s=%b expected se=0 s=00", se_1, sl1);
    end
    step(1'b1, 1'b1, 2'b10);
    tests++;
    if (sl1 !== 2'b01 || se_1 !== 1'b0) begin
      failed++;
      $display("FAIL missing_sync_reacquire got s=%b se=%b expected s=01 se=0", sl1, se_1);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset(1);
    good_frame();
    step(1'b1, 1'b1, 2'b11);
    step(1'b1, 1'b0, 2'b11);
    step(1'b1, 1'b0, 2'b11);
    do_reset(1);
    tests++;
    if ({w0, sl0, fd_0, se_0} !== 12'h0) begin
      failed++;
      $display("FAIL midreset got %h expected 000", {w0, sl0, fd_0, se_0});
    end
    step(1'b1, 1'b1, 2'b01);
    step(1'b1, 1'b0, 2'b10);
    step(1'b1, 1'b0, 2'b11);
    step(1'b1, 1'b0, 2'b00);
    tests++;
    if (w0 !== 8'h6C || w1 !== 8'h6C || fd_0 !== 1'b1) begin
      failed++;
      $display("FAIL midreset_frame got w0=%h w1=%h fd=%b expected 6c 6c 1", w0, w1, fd_0);
    end
  endtask

  initial begin
    rst = 1'b1;
    valid = 1'b0;
    sync = 1'b0;
    in1 = 1'b0;
    in0 = 1'b0;
    test_reset();
    test_aligned_frame();
    test_gapped_back_to_back();
    test_unaligned();
    test_early_resync();
    test_missing_sync();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
